// File: rtl/param_rom_stream_ctrl_pkg.sv
// Shared types and helpers for the parameter-ROM stream controller.
//   state_e    : sequencer states
//   inflight_t : one stage of the read-in-flight tracker
//   fifo_depth : output FIFO depth needed for full throughput at a given ROM latency
package param_rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } inflight_t;

    // One slot per read in flight, one for the word being presented and one
    // to absorb the pop that is not anticipated by the issue rule.
    function automatic int unsigned fifo_depth(input int unsigned read_latency);
        return read_latency + 32'd2;
    endfunction

endpackage

// File: rtl/param_rom_stream_ctrl_if.sv
// Bundle of control, ROM and output-stream signals of the ROM stream controller.
//   master : the controller (drives ROM address/enable, stream, busy/done)
//   slave  : the environment (drives start/passes/abort, rom_q, ready)
interface param_rom_stream_ctrl_if #(
    parameter int unsigned PRECISION   = 16,
    parameter int unsigned PARALLELISM = 1,
    parameter int unsigned PASS_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 6
);

    logic                               start;
    logic [PASS_WIDTH-1:0]              passes;
    logic                               abort;
    logic                               busy;
    logic                               done;

    logic [ADDR_WIDTH-1:0]              rom_addr;
    logic                               rom_ce;
    logic [PRECISION*PARALLELISM-1:0]   rom_q;

    logic [PRECISION-1:0]               data_out [PARALLELISM];
    logic                               data_out_last;
    logic                               data_out_valid;
    logic                               data_out_ready;

    modport master (
        input  start, passes, abort, rom_q, data_out_ready,
        output busy, done, rom_addr, rom_ce, data_out, data_out_last, data_out_valid
    );

    modport slave (
        output start, passes, abort, rom_q, data_out_ready,
        input  busy, done, rom_addr, rom_ce, data_out, data_out_last, data_out_valid
    );

endinterface

// File: rtl/param_rom_stream_ctrl_fifo.sv
// Small synchronous FIFO holding returned ROM words until the consumer accepts them.
// Head word is read straight from storage (first-word-fall-through); storage is not reset.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : drop all contents (takes priority over push/pop)
//   push_i        : write push_data_i (ignored when full)
//   pop_i         : advance head (ignored when empty)
//   head_data_o   : head word, zero when empty
//   head_valid_o  : FIFO not empty
//   count_o       : number of stored words
module param_stream_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    // Pointer advance with wrap for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        do_push = push_i && !full && !clear_i;
        do_pop  = pop_i && !empty && !clear_i;
    end

    // Storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_valid_o = !empty;
    assign head_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// Read sequencer for a parameter ROM with fixed read latency. Issues addresses
// 0..DEPTH-1 for a programmed number of passes (0 = endless), tracks reads in
// flight and lands returned words in a credit-managed FIFO feeding a
// valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master modport of param_rom_stream_ctrl_if
//              start/passes/abort in, busy/done out,
//              rom_addr/rom_ce out, rom_q in,
//              data_out[]/data_out_last/data_out_valid out, data_out_ready in
module param_rom_stream_ctrl
    import param_rom_stream_pkg::*;
#(
    parameter int unsigned PRECISION    = 16,
    parameter int unsigned PARALLELISM  = 1,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned PASS_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    param_rom_stream_ctrl_if.master bus
);

    localparam int unsigned WORD_W     = PRECISION * PARALLELISM;
    localparam int unsigned FIFO_W     = WORD_W + 1;
    localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W      = CNT_W + 1;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [PASS_WIDTH-1:0]  pass_q;
    logic [PASS_WIDTH-1:0]  passes_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rom_ce_q;
    inflight_t              pipe_q [READ_LATENCY];
    logic [CNT_W-1:0]       inflight_q;

    logic [CNT_W-1:0]       fifo_count;
    logic [FIFO_W-1:0]      fifo_head;
    logic                   fifo_head_valid;

    inflight_t              tail;
    logic                   addr_at_end;
    logic                   final_issue;
    logic [SUM_W-1:0]       occupancy;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   fifo_clear;
    logic                   fifo_empty_next;
    logic                   inflight_empty_next;

    // Issue credit, FIFO traffic and drain/flush completion terms
    always_comb begin
        tail        = pipe_q[READ_LATENCY-1];
        addr_at_end = (addr_q == ADDR_WIDTH'(DEPTH - 1));
        final_issue = addr_at_end && (passes_q != '0) &&
                      (pass_q == passes_q - PASS_WIDTH'(1));
        // Credits count buffered words plus reads still inside the ROM so
        // every returning word is guaranteed a FIFO slot.
        occupancy   = SUM_W'(fifo_count) + SUM_W'(inflight_q);
        issue       = (state_q == RUN) && !bus.abort &&
                      (occupancy < SUM_W'(FIFO_DEPTH));
        push        = tail.valid && (state_q != FLUSH);
        pop         = fifo_head_valid && bus.data_out_ready;
        fifo_clear  = bus.abort && ((state_q == RUN) || (state_q == DRAIN));
        // No issues happen in DRAIN/FLUSH, so only retirement matters here.
        fifo_empty_next     = ((SUM_W'(fifo_count) + SUM_W'(push)) == SUM_W'(pop));
        inflight_empty_next = (inflight_q == CNT_W'(tail.valid));
    end

    // Sequencer, address/pass counters and in-flight tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            passes_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_ce_q   <= 1'b0;
            inflight_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(tail.valid);

            pipe_q[0].valid <= issue;
            pipe_q[0].last  <= addr_at_end;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end

            if (issue) begin
                if (addr_at_end) begin
                    addr_q <= '0;
                    pass_q <= pass_q + PASS_WIDTH'(1);
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q  <= RUN;
                        passes_q <= bus.passes;
                        addr_q   <= '0;
                        pass_q   <= '0;
                        busy_q   <= 1'b1;
                        rom_ce_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= FLUSH;
                    end else if (issue && final_issue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // done is raised once everything has left; the state is
                    // held for that pulse cycle so busy covers it.
                    if (bus.abort) begin
                        state_q <= FLUSH;
                    end else if (done_q) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        rom_ce_q <= 1'b0;
                    end else if (fifo_empty_next && inflight_empty_next) begin
                        done_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (inflight_empty_next) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        rom_ce_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    rom_ce_q <= 1'b0;
                end
            endcase
        end
    end

    param_stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (fifo_clear),
        .push_i       (push),
        .push_data_i  ({tail.last, bus.rom_q}),
        .pop_i        (pop),
        .head_data_o  (fifo_head),
        .head_valid_o (fifo_head_valid),
        .count_o      (fifo_count)
    );

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.rom_addr       = addr_q;
    assign bus.rom_ce         = rom_ce_q;
    assign bus.data_out_valid = fifo_head_valid;
    assign bus.data_out_last  = fifo_head[FIFO_W-1];

    // Element j of the stream word
    for (genvar j = 0; j < int'(PARALLELISM); j++) begin : g_unpack
        assign bus.data_out[j] = fifo_head[PRECISION*j +: PRECISION];
    end

endmodule
